seq_mul: RTL and testbench



---
 rtl/seq_mul_if.sv | 21 ++
 rtl/seq_mul.sv | 132 +++++++++++++
 tb/tb_seq_mul.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_mul_if.sv
// Handshake and operand/result bundle between a multiply controller and seq_mul.
interface seq_mul_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier (radix-2 Booth when SEQ_MUL_SIGNED_EN is defined).
// Latency: done and product arrive in the cycle after edge E+WIDTH, where E is the accepting edge.
// Backpressure: none; start is only honoured in IDLE, so one operation is in flight at a time.
module seq_mul #(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     rst_n,
    seq_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_step;
    logic [WIDTH:0]       upper_sum;
    logic [WIDTH-1:0]     mcand;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic                 last_step;
    logic                 busy;
    logic                 done;

    assign last_step   = (cnt == CW'(WIDTH - 1));
    assign bus.product = product_q;
    assign bus.busy    = busy;
    assign bus.done    = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SEQ_MUL_SIGNED_EN
    // Guard holds the multiplier bit shifted out last step; {lsb, guard} selects the Booth action.
    logic           guard;
    logic [WIDTH:0] mcand_ext;

    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        upper_sum = acc[AW-1:WIDTH];
        case ({acc[0], guard})
            2'b10:   upper_sum = acc[AW-1:WIDTH] - mcand_ext;
            2'b01:   upper_sum = acc[AW-1:WIDTH] + mcand_ext;
            default: upper_sum = acc[AW-1:WIDTH];
        endcase
        acc_step = {upper_sum[WIDTH], upper_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            guard <= 1'b0;
        end else if (state == RUN) begin
            guard <= acc[0];
        end
    end
`else
    // Upper WIDTH+1 bits leave room for the carry out of each partial-product add.
    always_comb begin
        upper_sum = acc[AW-1:WIDTH];
        if (acc[0]) begin
            upper_sum = acc[AW-1:WIDTH] + {1'b0, mcand};
        end
        acc_step = {1'b0, upper_sum, acc[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.multiplicand;
                        acc   <= {{(WIDTH + 1){1'b0}}, bus.multiplier};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        product_q <= acc_step[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: reset state, products, latency, start interference and mid-run reset.
module tb_seq_mul;
    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_mul_if #(.WIDTH(WIDTH)) bus ();

    seq_mul #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one multiply, optionally poke start and the operands mid-run, then check result and timing.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input bit disturb);
        int cycles;
        int busy_n;
        cycles = 0;
        busy_n = 0;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && cycles < 100) begin
            if (bus.busy) busy_n++;
            if (disturb && cycles == 5) begin
                bus.start        = 1'b1;
                bus.multiplicand = ~a;
                bus.multiplier   = ~b;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'd16);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
        check({tag, "_product"}, bus.product, exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_product_hold"}, bus.product, exp);
    endtask

    initial begin
        int k;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_product", bus.product, 32'h0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;

        run_mul("m82x1", 16'h0082, 16'h0001, 32'h0000_0082, 1'b0);
        run_mul("m3x1", 16'h0003, 16'h0001, 32'h0000_0003, 1'b0);
        run_mul("m82x2", 16'h0082, 16'h0002, 32'h0000_0104, 1'b0);
        run_mul("m0x1234", 16'h0000, 16'h1234, 32'h0000_0000, 1'b0);
`ifdef SEQ_MUL_SIGNED_EN
        run_mul("s_m2x3", 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0);
        run_mul("s_min_sq", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
        run_mul("s_m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
        run_mul("s_disturb", 16'h0007, 16'hFFFD, 32'hFFFF_FFEB, 1'b1);
`else
        run_mul("mffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
        run_mul("disturb", 16'h1234, 16'h0010, 32'h0001_2340, 1'b1);
`endif

        // Held start: consecutive launches are WIDTH+2 cycles apart.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 16'h0003;
        bus.multiplier   = 16'h0004;
        k = 0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("held_first_product", bus.product, 32'h0000_000C);
        k = 0;
        @(negedge clk);
        k++;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check("held_interval", 32'(k), 32'd18);
        @(negedge clk);
        @(negedge clk);
        check("held_released_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 16'h0101;
        bus.multiplier   = 16'h0101;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_product", bus.product, 32'h0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mul("after_rst_5x7", 16'h0005, 16'h0007, 32'h0000_0023, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
